// File: rtl/aes_cp_pkg.sv
// Shared definitions for the aes256_coprocessor bus sequencer: register map,
// status bits and sequencer states.
package aes_cp_pkg;

   localparam logic [3:0] CP_STATUS = 4'd0;
   localparam logic [3:0] CP_NONCE0 = 4'd1;
   localparam logic [3:0] CP_KEY0   = 4'd5;
   localparam logic [3:0] CP_DIN    = 4'd13;
   localparam logic [3:0] CP_DOUT   = 4'd14;

   localparam int unsigned STATUS_RUN  = 0;
   localparam int unsigned STATUS_SRST = 1;

   typedef enum logic [3:0] {
      StIdle,
      StNonce,
      StKey,
      StData,
      StRun,
      StWait,
      StRead,
      StResp,
      StAbort
   } cp_state_e;

endpackage

// File: rtl/aes_cp_master.sv
// Sequences one AES-CTR block through the coprocessor register port:
// optional context load, data load, run, wait for interrupt, read back.
module aes_cp_master
   import aes_cp_pkg::*;
#(
   parameter int unsigned WAIT_TIMEOUT    = 4096,
   parameter bit          SOFT_RST_ON_ERR = 1'b1
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         cmd_valid,
   output logic         cmd_ready,
   input  logic         cmd_load_ctx,
   input  logic [255:0] cmd_key,
   input  logic [127:0] cmd_nonce,
   input  logic [127:0] cmd_block,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [127:0] res_block,
   output logic         res_err,
   output logic [3:0]   cp_addr,
   output logic [31:0]  cp_wdata,
   output logic         cp_we,
   input  logic [31:0]  cp_rdata,
   input  logic         cp_irq
);

   localparam int unsigned TW = $clog2(WAIT_TIMEOUT + 1);

   cp_state_e      state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [TW-1:0]  wcnt_q, wcnt_d;
   logic [255:0]   key_q;
   logic [127:0]   nonce_q, blk_q, res_q;
   logic           err_q;
   logic           timeout;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      wcnt_d    = wcnt_q;
      cp_addr   = CP_STATUS;
      cp_wdata  = '0;
      cp_we     = 1'b0;
      cmd_ready = 1'b0;
      res_valid = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         StIdle: begin
            cmd_ready = 1'b1;
            if (cmd_valid) begin
               state_d = cmd_load_ctx ? StNonce : StData;
               cnt_d   = '0;
            end
         end
         StNonce: begin
            cp_addr  = CP_NONCE0 + cnt_q;
            cp_wdata = nonce_q[32*cnt_q[1:0] +: 32];
            cp_we    = 1'b1;
            if (cnt_q == 4'd3) begin
               state_d = StKey;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StKey: begin
            cp_addr  = CP_KEY0 + cnt_q;
            cp_wdata = key_q[32*cnt_q[2:0] +: 32];
            cp_we    = 1'b1;
            if (cnt_q == 4'd7) begin
               state_d = StData;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StData: begin
            cp_addr  = CP_DIN;
            cp_wdata = blk_q[32*cnt_q[1:0] +: 32];
            cp_we    = 1'b1;
            if (cnt_q == 4'd3) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StRun: begin
            cp_wdata[STATUS_RUN] = 1'b1;
            cp_we   = 1'b1;
            state_d = StWait;
            wcnt_d  = '0;
         end
         StWait: begin
            // First WAIT cycle blanks a stale interrupt level from the previous block.
            if (cp_irq && (wcnt_q != '0)) begin
               state_d = StRead;
               cnt_d   = '0;
            end else if (wcnt_q == TW'(WAIT_TIMEOUT)) begin
               timeout = 1'b1;
               cnt_d   = '0;
               state_d = SOFT_RST_ON_ERR ? StAbort : StResp;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         StRead: begin
            cp_addr = CP_DOUT;
            if (cnt_q == 4'd3) begin
               state_d = StResp;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StAbort: begin
            cp_wdata[STATUS_SRST] = (cnt_q == 4'd0);
            cp_we = 1'b1;
            if (cnt_q == 4'd1) begin
               state_d = StResp;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StResp: begin
            res_valid = 1'b1;
            if (res_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         key_q   <= '0;
         nonce_q <= '0;
         blk_q   <= '0;
         res_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state_q == StIdle && cmd_valid) begin
            key_q   <= cmd_key;
            nonce_q <= cmd_nonce;
            blk_q   <= cmd_block;
            res_q   <= '0;
            err_q   <= 1'b0;
         end
         // Capture and FIFO pop share the same edge.
         if (state_q == StRead) res_q[32*cnt_q[1:0] +: 32] <= cp_rdata;
         if (timeout) begin
            res_q <= '0;
            err_q <= 1'b1;
         end
         if (state_q == StResp && res_ready) err_q <= 1'b0;
      end
   end

   assign res_block = res_q;
   assign res_err   = err_q;

endmodule

// File: tb/tb_aes_cp_master.sv
// Directed bench for aes_cp_master with a behavioural coprocessor whose
// keystream is fixed to the AES-256 output for all-ones key and zero nonce.
module tb_aes_cp_master;

   localparam int unsigned TMO = 16;

   logic         clock, rst_n;
   logic         cmd_valid, cmd_ready, cmd_load_ctx;
   logic [255:0] cmd_key;
   logic [127:0] cmd_nonce, cmd_block;
   logic         res_valid, res_ready, res_err;
   logic [127:0] res_block;
   logic [3:0]   cp_addr;
   logic [31:0]  cp_wdata, cp_rdata;
   logic         cp_we, cp_irq;

   aes_cp_master #(
      .WAIT_TIMEOUT    (TMO),
      .SOFT_RST_ON_ERR (1'b1)
   ) dut (
      .clock        (clock),
      .rst_n        (rst_n),
      .cmd_valid    (cmd_valid),
      .cmd_ready    (cmd_ready),
      .cmd_load_ctx (cmd_load_ctx),
      .cmd_key      (cmd_key),
      .cmd_nonce    (cmd_nonce),
      .cmd_block    (cmd_block),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_block    (res_block),
      .res_err      (res_err),
      .cp_addr      (cp_addr),
      .cp_wdata     (cp_wdata),
      .cp_we        (cp_we),
      .cp_rdata     (cp_rdata),
      .cp_irq       (cp_irq)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Behavioural coprocessor: dout = din ^ keystream, irq one edge after run.
   logic [127:0] ks = 128'h2A06C292_CCEE34CF_60DC9DE4_FD042A1D;
   logic [31:0]  din [4];
   logic [31:0]  dout [4];
   logic [1:0]   dptr = 2'd0, optr = 2'd0;
   logic         irq = 1'b0, pend = 1'b0;
   logic         irq_en, irq_force;
   int           ecnt = 0, wr_n = 0, pops = 0;
   logic [3:0]   wr_addr [128];
   logic [31:0]  wr_data [128];
   int           wr_edge [128];

   assign cp_rdata = dout[optr];
   assign cp_irq   = (irq | irq_force) & irq_en;

   always @(posedge clock) begin
      ecnt <= ecnt + 1;
      if (pend) begin
         irq  <= 1'b1;
         pend <= 1'b0;
      end
      if (cp_we) begin
         if (wr_n < 128) begin
            wr_addr[wr_n] <= cp_addr;
            wr_data[wr_n] <= cp_wdata;
            wr_edge[wr_n] <= ecnt;
            wr_n <= wr_n + 1;
         end
         if (cp_addr == 4'd13) begin
            din[dptr] <= cp_wdata;
            dptr <= dptr + 2'd1;
         end else if (cp_addr == 4'd0 && cp_wdata[1]) begin
            dptr <= 2'd0;
            optr <= 2'd0;
            irq  <= 1'b0;
            pend <= 1'b0;
         end else if (cp_addr == 4'd0 && cp_wdata[0]) begin
            for (int i = 0; i < 4; i++) dout[i] <= din[i] ^ ks[32*i +: 32];
            optr <= 2'd0;
            irq  <= 1'b0;
            pend <= 1'b1;
         end
      end else if (cp_addr == 4'd14) begin
         optr <= optr + 2'd1;
         pops <= pops + 1;
      end
   end

   int n_checks = 0, n_errors = 0;
   int wbase, pbase, a0, lat;
   logic [127:0] rb;
   logic         re;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".flags"}, 256'({cmd_ready, res_valid, res_err}), 256'(3'b100));
      check({tag, ".res_block"}, 256'(res_block), 256'(0));
      check({tag, ".bus"}, 256'({cp_addr, cp_wdata, cp_we}), 256'(0));
   endtask

   task automatic start_cmd(input bit ctx, input logic [255:0] key, input logic [127:0] nonce,
                            input logic [127:0] blk);
      @(negedge clock);
      cmd_load_ctx = ctx;
      cmd_key      = key;
      cmd_nonce    = nonce;
      cmd_block    = blk;
      cmd_valid    = 1'b1;
      wbase        = wr_n;
      pbase        = pops;
      @(posedge clock);
      #1;
      a0 = ecnt - 1;
      cmd_valid    = 1'b0;
      cmd_load_ctx = ~ctx;
      cmd_key      = ~key;
      cmd_nonce    = ~nonce;
      cmd_block    = ~blk;
   endtask

   task automatic wait_res(input string tag);
      lat = 0;
      while (res_valid !== 1'b1 && lat < 400) begin
         @(posedge clock);
         #1;
         lat++;
      end
      if (res_valid !== 1'b1) check({tag, ".res_valid_timeout"}, 256'(res_valid), 256'(1));
      rb = res_block;
      re = res_err;
   endtask

   task automatic accept_res(input string tag, input int hold);
      for (int k = 0; k < hold; k++) begin
         check({tag, ".hold"}, 256'({res_valid, res_block, res_err, cmd_ready, cp_addr, cp_we}),
               256'({1'b1, rb, re, 1'b0, 4'd0, 1'b0}));
         @(posedge clock);
         #1;
      end
      res_ready = 1'b1;
      @(posedge clock);
      #1;
      res_ready = 1'b0;
      check({tag, ".after_accept"}, 256'({res_valid, cmd_ready}), 256'(2'b01));
   endtask

   task automatic check_writes(input string tag, input bit ctx, input logic [255:0] key,
                               input logic [127:0] nonce, input logic [127:0] blk,
                               input bit abort);
      logic [3:0]  ea [24];
      logic [31:0] ed [24];
      int          ee [24];
      int          n = 0;
      int          nrun;
      if (ctx) begin
         for (int i = 0; i < 4; i++) begin
            ea[n] = 4'(1 + i); ed[n] = nonce[32*i +: 32]; ee[n] = n + 1; n++;
         end
         for (int i = 0; i < 8; i++) begin
            ea[n] = 4'(5 + i); ed[n] = key[32*i +: 32]; ee[n] = n + 1; n++;
         end
      end
      for (int i = 0; i < 4; i++) begin
         ea[n] = 4'd13; ed[n] = blk[32*i +: 32]; ee[n] = n + 1; n++;
      end
      ea[n] = 4'd0; ed[n] = 32'd1; ee[n] = n + 1; n++;
      nrun = n;
      if (abort) begin
         ea[n] = 4'd0; ed[n] = 32'd2; ee[n] = nrun + TMO + 2; n++;
         ea[n] = 4'd0; ed[n] = 32'd0; ee[n] = nrun + TMO + 3; n++;
      end
      check({tag, ".wr_count"}, 256'(wr_n - wbase), 256'(n));
      for (int i = 0; i < n && i < wr_n - wbase; i++)
         check({tag, ".wr"}, 256'({wr_addr[wbase+i], wr_data[wbase+i], wr_edge[wbase+i] - a0}),
               256'({ea[i], ed[i], ee[i]}));
   endtask

   logic [255:0] k2;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_load_ctx = 1'b0; res_ready = 1'b0;
      cmd_key = '0; cmd_nonce = '0; cmd_block = '0;
      irq_en = 1'b1; irq_force = 1'b0;
      k2 = 256'h0f0e0d0c_0b0a0908_07060504_03020100_1f1e1d1c_1b1a1918_17161514_13121110;
      #12;
      check_reset("reset");
      @(negedge clock);
      rst_n = 1'b1;

      // Full context load, minimum latency.
      start_cmd(1'b1, '1, '0, '1);
      check("t1.cmd_ready_busy", 256'(cmd_ready), 256'(0));
      wait_res("t1");
      check("t1.latency", 256'(lat), 256'(23));
      check("t1.res", 256'({rb, re}), 256'({128'hD5F93D6D3311CB309F23621B02FBD5E2, 1'b0}));
      accept_res("t1", 0);
      check_writes("t1", 1'b1, '1, '0, '1, 1'b0);
      check("t1.pops", 256'(pops - pbase), 256'(4));

      // Feed the result back without context.
      start_cmd(1'b0, '0, '0, 128'hD5F93D6D3311CB309F23621B02FBD5E2);
      wait_res("t2");
      check("t2.latency", 256'(lat), 256'(11));
      check("t2.res", 256'({rb, re}), 256'({{128{1'b1}}, 1'b0}));
      accept_res("t2", 0);
      check_writes("t2", 1'b0, '0, '0, 128'hD5F93D6D3311CB309F23621B02FBD5E2, 1'b0);

      // Interrupt held high across the run: first WAIT cycle must ignore it.
      irq_force = 1'b1;
      start_cmd(1'b0, '0, '0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
      wait_res("t3");
      irq_force = 1'b0;
      check("t3.latency", 256'(lat), 256'(11));
      check("t3.res", 256'({rb, re}), 256'({128'h2A17E0A1_88BB52B8_E845375F_31D9C4E2, 1'b0}));
      check("t3.pops", 256'(pops - pbase), 256'(4));
      accept_res("t3", 0);

      // No interrupt: timeout, soft-reset abort writes.
      irq_en = 1'b0;
      start_cmd(1'b0, '0, '0, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321);
      wait_res("t4");
      check("t4.latency", 256'(lat), 256'(24));
      check("t4.res", 256'({rb, re}), 256'({128'h0, 1'b1}));
      check("t4.pops", 256'(pops - pbase), 256'(0));
      accept_res("t4", 0);
      check_writes("t4", 1'b0, '0, '0, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321, 1'b1);
      irq_en = 1'b1;

      // Result held while the client stalls.
      start_cmd(1'b0, '0, '0, '0);
      wait_res("t5");
      check("t5.res", 256'({rb, re}), 256'({128'h2A06C292_CCEE34CF_60DC9DE4_FD042A1D, 1'b0}));
      accept_res("t5", 10);

      // Asynchronous reset during KEY word 3.
      start_cmd(1'b1, k2, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, '1);
      repeat (7) @(posedge clock);
      #1;
      check("t6.key3", 256'({cp_addr, cp_wdata, cp_we}), 256'({4'd8, k2[127:96], 1'b1}));
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("t6.async");
      repeat (2) @(negedge clock);
      check_reset("t6.held");
      rst_n = 1'b1;
      start_cmd(1'b1, k2, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, '1);
      wait_res("t6b");
      check("t6b.latency", 256'(lat), 256'(23));
      check("t6b.res", 256'({rb, re}), 256'({128'hD5F93D6D3311CB309F23621B02FBD5E2, 1'b0}));
      accept_res("t6b", 0);
      check_writes("t6b", 1'b1, k2, 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C, '1, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/aes_cp_master.md
# aes_cp_master

Bus-side sequencer for `aes256_coprocessor`. It accepts one 128-bit block per command on a valid/ready interface, optionally with a new 256-bit key and 128-bit nonce. It then drives the coprocessor's 4-bit-address register port: context load, data load and run. It waits for `interrupt`, reads the four result words back and presents the 128-bit result on a second valid/ready interface. It replaces hand-coded CPU register sequences wherever a hardware client needs AES-CTR throughput.

## Interface
- `WAIT_TIMEOUT`, default 4096: maximum cycles in WAIT before the command is aborted with `res_err`.
- `SOFT_RST_ON_ERR`, default 1: if 1, an abort writes status=0x2 and then status=0x0 before the result is reported.
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  client has a command.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_load_ctx`  in  1  1 writes nonce and key before the data; 0 writes the data only.
- `cmd_key`  in  256  key; word k = bits [32k+31:32k].
- `cmd_nonce`  in  128  nonce; same word order.
- `cmd_block`  in  128  plaintext/ciphertext block; same word order.
- `res_valid`  out  1  result held until accepted.
- `res_ready`  in  1  client accepts the result.
- `res_block`  out  128  result block; word 0 = first word read.
- `res_err`  out  1  qualifies `res_valid`; 1 = timeout abort, `res_block` = 0.
- `cp_addr`  out  4  coprocessor register address.
- `cp_wdata`  out  32  coprocessor write data.
- `cp_we`  out  1  coprocessor write enable.
- `cp_rdata`  in  32  coprocessor read data (combinational from `cp_addr`).
- `cp_irq`  in  1  coprocessor done interrupt, level.

## Operation
- Coprocessor register map:
  - 0 = status (bit0 run, bit1 soft reset).
  - 1–4 = nonce words 0–3.
  - 5–12 = key words 0–7.
  - 13 = data-in port; four successive writes give words 0–3.
  - 14 = data-out port; each rising edge with addr=14 and we=0 pops one word.
- Command input: `cmd_*` is registered on the `cmd_valid && cmd_ready` edge. The client may change its inputs afterwards.
- States and transitions:
  - IDLE: go to NONCE if `load_ctx`, otherwise DATA.
  - NONCE: 4 writes, addr 1..4.
  - KEY: 8 writes, addr 5..12.
  - DATA: 4 writes to addr 13, words 0..3.
  - RUN: 1 write, addr 0, data 0x00000001.
  - WAIT: addr 0, we=0.
  - READ: 4 cycles at addr 14, we=0.
  - RESP: hold the result until accepted.
  - ABORT: only when `SOFT_RST_ON_ERR` is set.
- Every write state asserts `cp_we` for exactly one cycle per word, with a 4-bit word counter.
- Idle bus: addr=0, wdata=0, we=0. `cp_addr` is never 14 outside READ and never 13 outside DATA.
- WAIT:
  - The first WAIT cycle ignores `cp_irq` (a stale level from the previous block is blanked).
  - From the second cycle, `cp_irq`=1 at an edge moves to READ.
  - A cycle counter reaching `WAIT_TIMEOUT` moves to ABORT, or straight to RESP with err=1.
- READ: `cp_rdata` is captured into `res_block` word n on the n-th READ edge. The same edge pops the coprocessor FIFO.
- ABORT: 2 write cycles, status=0x2 then status=0x0, then RESP with `res_err`=1.
- RESP: `res_valid` stays high until `res_valid && res_ready` at an edge, which returns to IDLE. `cmd_ready` therefore rises the cycle after acceptance, so there is no back-to-back overlap.
- Mid-operation `rst_n` low clears everything at once. The coprocessor itself is not reset; the next command after reset must use `load_ctx`=1.

## Timing
- Reset values:
  - `cmd_ready`=1.
  - `res_valid`=0, `res_err`=0, `res_block`=0.
  - `cp_addr`=0, `cp_wdata`=0, `cp_we`=0.
  - State IDLE, all counters 0.
- Edge numbering: command accepted at edge 0; the first write is visible on the bus in cycle 1.
  - `load_ctx`=1: writes commit at edges 1–17 (nonce 1–4, key 5–12, data 13–16, run 17). WAIT starts in cycle 18.
  - `load_ctx`=0: writes commit at edges 1–5.
- If `cp_irq` is first sampled high at edge N (N ≥ WAIT start + 1):
  - reads happen at edges N+1..N+4;
  - `res_valid`=1 from cycle N+5.
- Minimum command-to-result latency:
  - 23 cycles with `load_ctx`=1;
  - 11 cycles with `load_ctx`=0.
- Timeout: `res_valid` rises `WAIT_TIMEOUT` + 1 cycles after WAIT entry, plus 2 cycles when the ABORT writes are performed.

## Structure
- Shared package `aes_cp_pkg`:
  - register address constants (`CP_STATUS`=0, `CP_NONCE0`=1, `CP_KEY0`=5, `CP_DIN`=13, `CP_DOUT`=14);
  - status bit positions;
  - the state enum.
- Single module; no sub-module needed. The word mux for `cp_wdata` is an indexed part-select on the registered command.

## Test plan
- Key all-ones, nonce 0, block all-ones, `load_ctx`=1, behavioural coprocessor model → write sequence is addr 1..12, 13×4, 0 (data 0x1) at edges 1–17. `res_block`=D5F93D6D3311CB309F23621B02FBD5E2, `res_err`=0.
- Feed that result back with `load_ctx`=0 → only 5 writes occur; `res_block`=FFFF…FFFF.
- `cp_irq` held high from before the run write → it is ignored for one WAIT cycle; READ starts exactly one cycle later; no early pop.
- `cp_irq` never asserts, `WAIT_TIMEOUT`=16 → ABORT writes 0x2 then 0x0; `res_valid` with `res_err`=1 and `res_block`=0.
- `res_ready` held low for 10 cycles → `res_valid`/`res_block` stable, `cmd_ready`=0, bus idle at addr 0.
- `rst_n` pulsed low during KEY word 3 → all outputs return to reset values asynchronously; the next command completes correctly.
